// File: rtl/idex_pipe_stage.sv
// ID/EX pipeline stage for the RV32I core: immediate generation, write-back bypass,
// load-use bubble insertion, flush and downstream stall handling into the EX register set.
module idex_pipe_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [31:0]       id_inst,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_is_load,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              id_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_opcode,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_is_load
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0]      opcode;
  logic [4:0]      rs1_idx;
  logic [4:0]      rs2_idx;
  logic [4:0]      rd_idx;
  logic [2:0]      funct3;
  logic [31:0]     imm32;
  logic [XLEN-1:0] id_imm;
  logic            uses_rs1;
  logic            uses_rs2;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic            hazard;
  logic            load_en;

  assign opcode  = id_inst[6:0];
  assign rd_idx  = id_inst[11:7];
  assign funct3  = id_inst[14:12];
  assign rs1_idx = id_inst[19:15];
  assign rs2_idx = id_inst[24:20];

  // Build the 32-bit immediate first, then sign-extend once to XLEN.
  always_comb begin
    imm32 = 32'd0;
    case (opcode)
      OPC_LOAD, OPC_OPIMM, OPC_JALR:
        imm32 = {{20{id_inst[31]}}, id_inst[31:20]};
      OPC_STORE:
        imm32 = {{20{id_inst[31]}}, id_inst[31:25], id_inst[11:7]};
      OPC_BRANCH:
        imm32 = {{19{id_inst[31]}}, id_inst[31], id_inst[7], id_inst[30:25],
                 id_inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm32 = {id_inst[31:12], 12'd0};
      OPC_JAL:
        imm32 = {{11{id_inst[31]}}, id_inst[31], id_inst[19:12], id_inst[20],
                 id_inst[30:21], 1'b0};
      default:
        imm32 = 32'd0;
    endcase
  end

  assign id_imm = XLEN'($signed(imm32));

  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: uses_rs1 = 1'b0;
      default:                     uses_rs1 = 1'b1;
    endcase
    case (opcode)
      OPC_OP, OPC_STORE, OPC_BRANCH: uses_rs2 = 1'b1;
      default:                       uses_rs2 = 1'b0;
    endcase
  end

  // x0 is never a bypass source, so a write-back to x0 cannot leak into operands.
  assign rs1_fwd = (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1_idx)) ? wb_data : id_rs1_data;
  assign rs2_fwd = (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2_idx)) ? wb_data : id_rs2_data;

  assign hazard = ex_valid && ex_is_load && (ex_rd != 5'd0) && id_valid &&
                  ((uses_rs1 && (ex_rd == rs1_idx)) || (uses_rs2 && (ex_rd == rs2_idx)));

  assign id_ready = RST || !((ex_stall && !flush) || (hazard && !flush));

  assign load_en = !flush && !ex_stall && !hazard;

  // Flush and bubble only clear the valid bit; payload registers keep their old contents.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_rd       <= 5'd0;
      ex_funct3   <= 3'd0;
      ex_opcode   <= 7'd0;
      ex_ctrl     <= '0;
      ex_is_load  <= 1'b0;
    end else begin
      if (flush || (!ex_stall && hazard)) begin
        ex_valid <= 1'b0;
      end else if (!ex_stall) begin
        ex_valid <= id_valid;
      end
      if (load_en) begin
        ex_pc       <= id_pc;
        ex_rs1_data <= rs1_fwd;
        ex_rs2_data <= rs2_fwd;
        ex_imm      <= id_imm;
        ex_rs1      <= rs1_idx;
        ex_rs2      <= rs2_idx;
        ex_rd       <= rd_idx;
        ex_funct3   <= funct3;
        ex_opcode   <= opcode;
        ex_ctrl     <= id_ctrl;
        ex_is_load  <= id_is_load;
      end
    end
  end

endmodule

// File: tb/tb_idex_pipe_stage.sv
// Directed bench for idex_pipe_stage: a behavioural reference model checked every cycle,
// plus hand-computed literal expectations at key points of the instruction sequence.
module tb_idex_pipe_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [15:0] id_ctrl;
  logic        id_is_load;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_stall;
  logic        flush;
  logic        id_ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_opcode;
  logic [15:0] ex_ctrl;
  logic        ex_is_load;

  int checks = 0;
  int errors = 0;

  idex_pipe_stage #(.XLEN(32), .CTRL_W(16)) dut (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_ctrl(id_ctrl), .id_is_load(id_is_load), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_stall(ex_stall), .flush(flush), .id_ready(id_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_opcode(ex_opcode), .ex_ctrl(ex_ctrl), .ex_is_load(ex_is_load)
  );

  always #5 CLK = ~CLK;

  // Reference model state: what the EX register set should hold.
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = '0, m_rs1_data = '0, m_rs2_data = '0, m_imm = '0;
  logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  logic [2:0]  m_funct3 = '0;
  logic [6:0]  m_opcode = '0;
  logic [15:0] m_ctrl = '0;
  logic        m_is_load = 1'b0;

  function automatic logic [31:0] model_imm(input logic [31:0] inst);
    logic [31:0] sign;
    sign = inst[31] ? 32'hFFFF_FFFF : 32'h0;
    case (inst[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: return 32'($signed(inst) >>> 20);
      7'b0100011: return (sign << 12) | (32'(inst[31:25]) << 5) | 32'(inst[11:7]);
      7'b1100011: return (sign << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5)
                         | (32'(inst[11:8]) << 1);
      7'b0110111, 7'b0010111: return inst & 32'hFFFF_F000;
      7'b1101111: return (sign << 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11)
                         | (32'(inst[30:21]) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_hazard();
    logic [6:0] op;
    logic       r1, r2;
    op = id_inst[6:0];
    r1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    r2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    return m_valid && m_is_load && m_rd != 0 && id_valid &&
           ((r1 && m_rd == id_inst[19:15]) || (r2 && m_rd == id_inst[24:20]));
  endfunction

  function automatic logic [31:0] model_operand(input logic [4:0] idx, input logic [31:0] rf);
    return (wb_we && wb_rd != 0 && wb_rd == idx) ? wb_data : rf;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_valid <= 0; m_pc <= 0; m_rs1_data <= 0; m_rs2_data <= 0; m_imm <= 0;
      m_rs1 <= 0; m_rs2 <= 0; m_rd <= 0; m_funct3 <= 0; m_opcode <= 0;
      m_ctrl <= 0; m_is_load <= 0;
    end else if (flush) begin
      m_valid <= 0;
    end else if (ex_stall) begin
      m_valid <= m_valid;
    end else if (model_hazard()) begin
      m_valid <= 0;
    end else begin
      m_valid    <= id_valid;
      m_pc       <= id_pc;
      m_rs1_data <= model_operand(id_inst[19:15], id_rs1_data);
      m_rs2_data <= model_operand(id_inst[24:20], id_rs2_data);
      m_imm      <= model_imm(id_inst);
      m_rs1      <= id_inst[19:15];
      m_rs2      <= id_inst[24:20];
      m_rd       <= id_inst[11:7];
      m_funct3   <= id_inst[14:12];
      m_opcode   <= id_inst[6:0];
      m_ctrl     <= id_ctrl;
      m_is_load  <= id_is_load;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: inputs and registers are both stable on the falling edge.
  always @(negedge CLK) begin
    checkOutput("m.id_ready", 64'(id_ready),
                64'(RST || flush || !(ex_stall || model_hazard())));
    checkOutput("m.ex_valid", 64'(ex_valid), 64'(m_valid));
    checkOutput("m.ex_pc", 64'(ex_pc), 64'(m_pc));
    checkOutput("m.ex_rs1_data", 64'(ex_rs1_data), 64'(m_rs1_data));
    checkOutput("m.ex_rs2_data", 64'(ex_rs2_data), 64'(m_rs2_data));
    checkOutput("m.ex_imm", 64'(ex_imm), 64'(m_imm));
    checkOutput("m.ex_rs1", 64'(ex_rs1), 64'(m_rs1));
    checkOutput("m.ex_rs2", 64'(ex_rs2), 64'(m_rs2));
    checkOutput("m.ex_rd", 64'(ex_rd), 64'(m_rd));
    checkOutput("m.ex_funct3", 64'(ex_funct3), 64'(m_funct3));
    checkOutput("m.ex_opcode", 64'(ex_opcode), 64'(m_opcode));
    checkOutput("m.ex_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
    checkOutput("m.ex_is_load", 64'(ex_is_load), 64'(m_is_load));
  end

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                               input logic ld, input logic [31:0] r1, input logic [31:0] r2,
                               input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                               input logic st, input logic fl, input logic rs);
    @(posedge CLK);
    #2;
    id_valid = v; id_pc = pc; id_inst = inst; id_ctrl = pc[15:0] ^ 16'h5A5A;
    id_is_load = ld; id_rs1_data = r1; id_rs2_data = r2;
    wb_we = we; wb_rd = wrd; wb_data = wd; ex_stall = st; flush = fl; RST = rs;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    RST = 1; id_valid = 0; id_pc = 0; id_inst = 0; id_ctrl = 0; id_is_load = 0;
    id_rs1_data = 0; id_rs2_data = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    ex_stall = 0; flush = 0;

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    @(negedge CLK);
    checkOutput("rst.id_ready", 64'(id_ready), 64'd1);
    checkOutput("rst.ex_valid", 64'(ex_valid), 64'd0);
    checkOutput("rst.ex_pc", 64'(ex_pc), 64'd0);

    // Immediate formats
    applyStimulus(1, 32'h100, 32'hFFF0_0093, 0, 32'h11, 32'h22, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h104, 32'h8000_00EF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("imm.addi", 64'(ex_imm), 64'hFFFF_FFFF);
    checkOutput("imm.addi_pc", 64'(ex_pc), 64'h100);
    checkOutput("imm.addi_valid", 64'(ex_valid), 64'd1);
    applyStimulus(1, 32'h108, 32'h1234_5037, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("imm.jal", 64'(ex_imm), 64'hFFF0_0000);
    applyStimulus(1, 32'h10C, 32'hFE00_0EE3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("imm.lui", 64'(ex_imm), 64'h1234_5000);

    // Load-use: lw x5 then add x6,x5,x7
    applyStimulus(1, 32'h110, 32'h0000_A283, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("imm.beq", 64'(ex_imm), 64'hFFFF_FFFC);
    applyStimulus(1, 32'h114, 32'h0072_8333, 0, 32'h55, 32'h77, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("lu.id_ready_low", 64'(id_ready), 64'd0);
    applyStimulus(1, 32'h114, 32'h0072_8333, 0, 32'h55, 32'h77, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("lu.bubble", 64'(ex_valid), 64'd0);
    checkOutput("lu.id_ready_back", 64'(id_ready), 64'd1);
    applyStimulus(1, 32'h118, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("lu.add_valid", 64'(ex_valid), 64'd1);
    checkOutput("lu.add_rs1", 64'(ex_rs1), 64'd5);
    checkOutput("lu.add_rd", 64'(ex_rd), 64'd6);

    // lw x5 followed by lui x5,0x28 (rs1 field is 5 but unused): no stall
    applyStimulus(1, 32'h11C, 32'h0000_A283, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h120, 32'h0002_82B7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("lu.lui_no_stall", 64'(id_ready), 64'd1);
    applyStimulus(1, 32'h124, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("lu.lui_opcode", 64'(ex_opcode), 64'h37);
    checkOutput("lu.lui_valid", 64'(ex_valid), 64'd1);

    // Bypass from write-back, then a write to x0 that must not bypass
    applyStimulus(1, 32'h128, 32'h0001_8433, 0, 0, 32'h9, 1, 5'd3, 32'hDEAD_BEEF, 0, 0, 0);
    applyStimulus(1, 32'h12C, 32'h0000_0433, 0, 0, 0, 1, 5'd0, 32'hDEAD_BEEF, 0, 0, 0);
    @(negedge CLK);
    checkOutput("byp.wb_x3", 64'(ex_rs1_data), 64'hDEAD_BEEF);
    checkOutput("byp.rs2_plain", 64'(ex_rs2_data), 64'h9);
    applyStimulus(1, 32'h130, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("byp.wb_x0", 64'(ex_rs1_data), 64'd0);

    // Flush wins over stall
    applyStimulus(1, 32'h134, NOP, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    @(negedge CLK);
    checkOutput("fl.id_ready", 64'(id_ready), 64'd1);
    applyStimulus(0, 32'h138, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("fl.ex_valid", 64'(ex_valid), 64'd0);

    // Stall hold for three cycles while ID changes
    applyStimulus(1, 32'h200, NOP, 0, 32'h1, 32'h2, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h300 + 32'(i * 4), 32'h0010_0093 + 32'(i << 20), 0,
                    32'hA0 + 32'(i), 32'hB0, 0, 0, 0, 1, 0, 0);
      @(negedge CLK);
      checkOutput("st.id_ready", 64'(id_ready), 64'd0);
      checkOutput("st.hold_pc", 64'(ex_pc), 64'h200);
    end
    applyStimulus(1, 32'h300, 32'h0030_0093, 0, 32'hC0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 32'h0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("st.release_pc", 64'(ex_pc), 64'h300);
    checkOutput("st.release_imm", 64'(ex_imm), 64'h3);

    // Reset in the middle of operation
    applyStimulus(1, 32'h100, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h500, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge CLK);
    checkOutput("mr.pre_pc", 64'(ex_pc), 64'h100);
    checkOutput("mr.rst_ready", 64'(id_ready), 64'd1);
    applyStimulus(1, 32'h400, 32'hFFF0_0093, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("mr.valid", 64'(ex_valid), 64'd0);
    checkOutput("mr.pc", 64'(ex_pc), 64'd0);
    checkOutput("mr.ctrl", 64'(ex_ctrl), 64'd0);
    applyStimulus(0, 32'h0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("mr.after_pc", 64'(ex_pc), 64'h400);
    checkOutput("mr.after_valid", 64'(ex_valid), 64'd1);

    @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/idex_pipe_stage.md
# idex_pipe_stage

Parametrised ID/EX pipeline stage for the RV32I core. It sits between the decoder/register file and the execute stage. Each cycle it generates the sign-extended immediate for every base instruction format and captures operands, register indices, PC and an opaque decoded-control bundle into the EX register set. It also adds what the first-generation stage lacked: synchronous reset, a valid bit, flush, downstream stall, load-use bubble insertion, and write-back-to-decode operand bypass.

## Interface
- XLEN, 32, datapath width; immediates are sign-extended to XLEN.
- CTRL_W, 16, width of the opaque control bundle from the control unit.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  PC of ID instruction.
- id_inst  in  32  raw instruction word.
- id_ctrl  in  CTRL_W  decoded control bundle, passed through unchanged.
- id_is_load  in  1  ID instruction is a load.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- wb_we  in  1  write-back write enable.
- wb_rd  in  5  write-back destination register.
- wb_data  in  XLEN  write-back data.
- ex_stall  in  1  EX cannot accept; hold the stage.
- flush  in  1  branch/jump redirect; kill the instruction entering EX.
- id_ready  out  1  combinational; 0 means IF/ID must hold its contents.
- ex_valid  out  1  EX register holds a real instruction.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered operands.
- ex_rs1, ex_rs2, ex_rd  out  5  registered inst[19:15], inst[24:20], inst[11:7].
- ex_funct3  out  3; ex_opcode  out  7; ex_ctrl  out  CTRL_W; ex_is_load  out  1.

## Operation
- Immediate is selected by opcode = id_inst[6:0]:
  - I-type (0000011, 0010011, 1100111): sext(inst[31:20]).
  - S-type (0100011): sext({inst[31:25], inst[11:7]}).
  - B-type (1100011): sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U-type (0110111, 0010111): sext({inst[31:12], 12'b0}).
  - J-type (1101111): sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - Any other opcode: 0.
- Source usage:
  - uses_rs1 is true for all opcodes except 0110111, 0010111 and 1101111.
  - uses_rs2 is true only for 0110011, 0100011 and 1100011.
- Bypass: if wb_we, wb_rd != 0 and wb_rd == inst[19:15], capture wb_data as rs1 data, else id_rs1_data. rs2 is handled identically.
- Hazard = ex_valid & ex_is_load & ex_rd != 0 & id_valid & ((uses_rs1 & ex_rd == inst[19:15]) | (uses_rs2 & ex_rd == inst[24:20])).
- Per-cycle action, highest priority first:
  - RST: all registered outputs become 0.
  - flush: ex_valid becomes 0 and the other registers hold. flush overrides ex_stall and hazard.
  - ex_stall: all EX registers hold.
  - hazard: bubble. ex_valid becomes 0 and the other registers hold.
  - else: all EX registers load from ID; ex_valid becomes id_valid.
- id_ready = !((ex_stall & !flush) | (hazard & !flush)). With flush high, id_ready = 1; upstream discards IF/ID itself.
- Held operand data is never refreshed by write-back. Late write-backs are handled by the EX forwarding unit.

## Timing
- One-cycle latency from ID to EX outputs. There is no combinational path from ID inputs to EX outputs.
- id_ready is combinational, from the current ex_* state plus ex_stall, flush, id_inst and id_valid.
- Reset values:
  - While RST is asserted, id_ready = 1.
  - After RST, every ex_* output is 0, including ex_valid.
- Load-use costs exactly one bubble cycle. On the next cycle ex_valid = 0, so hazard clears and the held ID instruction advances.
- Simultaneous hazard and ex_stall: stall wins, so nothing changes. Hazard re-evaluates when the stall drops.
- A wb_rd == 0 write never bypasses. A load with ex_rd == 0 never stalls.

## Test plan
- Immediate: 0xFFF00093 (addi x1,x0,-1) → ex_imm = 0xFFFFFFFF. 0x800000EF (jal x1,-1048576) → ex_imm = 0xFFF00000. 0x12345037 (lui x0,0x12345) → ex_imm = 0x12345000. 0xFE000EE3 (beq x0,x0,-4) → ex_imm = 0xFFFFFFFC.
- Load-use:
  - EX holds lw x5 (ex_is_load = 1, ex_rd = 5) and ID holds add x6,x5,x7 → id_ready = 0, next ex_valid = 0.
  - The following cycle the add enters EX with ex_rs1 = 5.
  - If ID instead holds lui x5,… → no stall.
- Bypass: wb_we = 1, wb_rd = 3, wb_data = 0xDEADBEEF; ID instruction reads x3 with id_rs1_data = 0 → ex_rs1_data = 0xDEADBEEF. Repeat with wb_rd = 0 → ex_rs1_data = 0.
- Flush priority: flush = 1 together with ex_stall = 1 and a valid ID instruction → next ex_valid = 0, id_ready = 1.
- Stall hold: ex_stall = 1 for 3 cycles while ID inputs change → all ex_* outputs constant and id_ready = 0. After release, the ID instruction is captured in one cycle.
- Reset mid-operation: with ex_valid = 1 and ex_pc = 0x100, assert RST for one cycle → all ex_* outputs = 0. The next valid ID instruction is captured normally.
